// File: rtl/store_load_queue_pkg.sv
// Shared widths, store-buffer entry layout and opcode helpers for the load/store queue.
package store_load_queue_pkg;

    localparam int DATA_W   = 16;
    localparam int INSTR_W  = 6;
    localparam int RSV_ID_W = 5;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef enum logic [INSTR_W-1:0] {
        OP_LOAD  = 6'h10,
        OP_STORE = 6'h11,
        OP_IN    = 6'h12,
        OP_OUT   = 6'h13
    } mem_op_e;

    typedef struct packed {
        logic                valid;
        logic                committed;
        logic                invalidate;
        logic                data_ready;
        logic [RSV_ID_W-1:0] rob_id;
        logic [INSTR_W-1:0]  opcode;
        logic [DATA_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic [RSV_ID_W-1:0] data_rob_id;
    } sb_entry_t;

    function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
        return (op == OP_STORE) || (op == OP_OUT);
    endfunction

    function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_IN);
    endfunction

endpackage

// File: rtl/store_load_queue_match_finder.sv
// Youngest-match search over the circular store buffer; walks oldest to youngest from head
// so the last hit seen is the youngest store to the queried address.
module sb_match_finder #(
    parameter int SB_DEPTH = 8,
    parameter int ADDR_W   = 16,
    localparam int PTR_W   = $clog2(SB_DEPTH)
) (
    input  logic [SB_DEPTH-1:0]             valid,
    input  logic [SB_DEPTH-1:0][ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0]               query,
    input  logic [PTR_W-1:0]                head,
    output logic                            hit,
    output logic [PTR_W-1:0]                index
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (address[idx] == query)) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/store_load_queue.sv
// In-order load/store queue: buffers stores until commit, drains them to memory,
// and bypasses, forwards or stalls loads against the buffered stores.
module store_load_queue
    import store_load_queue_pkg::*;
#(
    parameter int                SB_DEPTH     = 8,
    parameter bit                FORWARD_EN   = 1'b1,
    parameter int                STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] IO_ADDR      = '1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic                a_is_store,
    input  logic [INSTR_W-1:0]  a_opcode,
    input  logic [RSV_ID_W-1:0] a_rob_id,
    input  logic [DATA_W-1:0]   a_address,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [RSV_ID_W-1:0] a_data_rob_id,
    input  logic                a_data_ready,
    input  logic [CDB_W-1:0]    cdb,
    input  logic                cdb_valid,
    input  logic                commit_valid,
    input  logic [RSV_ID_W-1:0] commit_id,
    input  logic                commit_invalidate,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [INSTR_W-1:0]  m_opcode,
    output logic [RSV_ID_W-1:0] m_rob_id,
    output logic [DATA_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_data,
    output logic                f_cdb_valid,
    input  logic                f_cdb_ready,
    output logic [CDB_W-1:0]    f_cdb
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    sb_entry_t          sb   [SB_DEPTH];
    sb_entry_t          sb_n [SB_DEPTH];
    logic [PTR_W-1:0]   head, tail, head_n, tail_n;
    logic [CNT_W-1:0]   count, count_n, kept;
    logic [ST_W-1:0]    starve_cnt, starve_n;

    logic [SB_DEPTH-1:0]             valid_vec;
    logic [SB_DEPTH-1:0][DATA_W-1:0] addr_vec;
    logic                            hit;
    logic [PTR_W-1:0]                hit_idx;

    logic [RSV_ID_W-1:0] cdb_tag;
    logic [DATA_W-1:0]   cdb_data;
    logic full, is_io, load_req, load_bypass, load_fwd;
    logic head_drain, head_inval, starved, store_win, load_grant;
    logic store_push, store_pop, new_snoop;

    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            valid_vec[i] = sb[i].valid;
            addr_vec[i]  = sb[i].address;
        end
    end

    sb_match_finder #(.SB_DEPTH(SB_DEPTH), .ADDR_W(DATA_W)) u_match (
        .valid   (valid_vec),
        .address (addr_vec),
        .query   (a_address),
        .head    (head),
        .hit     (hit),
        .index   (hit_idx)
    );

    assign cdb_tag  = cdb[CDB_W-1 -: RSV_ID_W];
    assign cdb_data = cdb[DATA_W-1:0];
    assign full     = (count == CNT_W'(SB_DEPTH));
    assign is_io    = (a_address == IO_ADDR);

    // IO loads must not pass any buffered store, matching or not.
    assign load_req    = !nrst && a_valid && !a_is_store && !flush;
    assign load_bypass = load_req && (is_io ? (count == '0) : !hit);
    assign load_fwd    = load_req && FORWARD_EN && hit && !is_io && sb[hit_idx].data_ready;

    assign head_drain = !nrst && sb[head].valid && sb[head].committed
                        && sb[head].data_ready && !sb[head].invalidate;
    assign head_inval = !nrst && sb[head].valid && sb[head].committed && sb[head].invalidate;
    assign starved    = (starve_cnt == ST_W'(STARVE_LIMIT));
    assign store_win  = head_drain && (!load_bypass || starved);
    assign load_grant = load_bypass && !store_win;

    assign store_push = !nrst && a_valid && a_is_store && !full && !flush;
    assign store_pop  = (store_win && m_ready) || head_inval;
    assign new_snoop  = cdb_valid && (cdb_tag == a_data_rob_id);

    always_comb begin
        m_valid     = store_win || load_grant;
        m_opcode    = '0;
        m_rob_id    = '0;
        m_address   = '0;
        m_data      = '0;
        if (store_win) begin
            m_opcode  = sb[head].opcode;
            m_rob_id  = sb[head].rob_id;
            m_address = sb[head].address;
            m_data    = sb[head].data;
        end else if (load_grant) begin
            m_opcode  = a_opcode;
            m_rob_id  = a_rob_id;
            m_address = a_address;
        end
        f_cdb_valid = load_fwd;
        f_cdb       = load_fwd ? {a_rob_id, sb[hit_idx].data} : '0;
        a_ready     = store_push || (load_grant && m_ready) || (load_fwd && f_cdb_ready);
    end

    always_comb begin
        sb_n    = sb;
        head_n  = head;
        tail_n  = tail;
        kept    = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb[i].valid && !sb[i].data_ready && cdb_valid && (sb[i].data_rob_id == cdb_tag)) begin
                sb_n[i].data_ready = 1'b1;
                sb_n[i].data       = cdb_data;
            end
            if (commit_valid && sb[i].valid && !sb[i].committed && (sb[i].rob_id == commit_id)) begin
                sb_n[i].committed  = 1'b1;
                sb_n[i].invalidate = commit_invalidate;
            end
        end
        if (store_pop) begin
            sb_n[head].valid = 1'b0;
            head_n           = head + PTR_W'(1);
        end
        if (store_push) begin
            sb_n[tail] = '{valid: 1'b1, committed: 1'b0, invalidate: 1'b0,
                           data_ready: a_data_ready || new_snoop,
                           rob_id: a_rob_id, opcode: a_opcode, address: a_address,
                           data: a_data_ready ? a_data : cdb_data,
                           data_rob_id: a_data_rob_id};
            tail_n = tail + PTR_W'(1);
        end
        count_n = count + CNT_W'(store_push) - CNT_W'(store_pop);
        // Committed stores sit contiguously from head, so the survivors end at head+kept.
        if (flush) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (sb_n[i].valid && sb_n[i].committed) kept = kept + CNT_W'(1);
                else                                     sb_n[i].valid = 1'b0;
            end
            tail_n  = head_n + PTR_W'(kept);
            count_n = kept;
        end
    end

    always_comb begin
        if (!head_drain || (store_win && m_ready)) starve_n = '0;
        else if (load_grant && !starved)           starve_n = starve_cnt + ST_W'(1);
        else                                       starve_n = starve_cnt;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb[i].valid <= 1'b0;
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            count      <= count_n;
            starve_cnt <= starve_n;
            sb         <= sb_n;
        end
    end

endmodule

// File: tb/tb_store_load_queue.sv
// Bench for store_load_queue: directed scenarios plus random traffic against a queue-based model.
module tb_store_load_queue;
    import store_load_queue_pkg::*;

    localparam int                SB_DEPTH     = 8;
    localparam int                STARVE_LIMIT = 4;
    localparam logic [DATA_W-1:0] IO_ADDR      = '1;

    logic clk, nrst;
    logic a_valid, a_ready, a_is_store, a_data_ready;
    logic [INSTR_W-1:0]  a_opcode;
    logic [RSV_ID_W-1:0] a_rob_id, a_data_rob_id, commit_id, m_rob_id;
    logic [DATA_W-1:0]   a_address, a_data, m_address, m_data;
    logic [CDB_W-1:0]    cdb, f_cdb;
    logic cdb_valid, commit_valid, commit_invalidate, flush;
    logic m_valid, m_ready, f_cdb_valid, f_cdb_ready;
    logic [INSTR_W-1:0]  m_opcode;

    store_load_queue #(.SB_DEPTH(SB_DEPTH), .FORWARD_EN(1'b1), .STARVE_LIMIT(STARVE_LIMIT),
                       .IO_ADDR(IO_ADDR)) dut (
        .clk(clk), .nrst(nrst), .a_valid(a_valid), .a_ready(a_ready), .a_is_store(a_is_store),
        .a_opcode(a_opcode), .a_rob_id(a_rob_id), .a_address(a_address), .a_data(a_data),
        .a_data_rob_id(a_data_rob_id), .a_data_ready(a_data_ready), .cdb(cdb), .cdb_valid(cdb_valid),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_invalidate(commit_invalidate),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_opcode(m_opcode), .m_rob_id(m_rob_id),
        .m_address(m_address), .m_data(m_data), .f_cdb_valid(f_cdb_valid), .f_cdb_ready(f_cdb_ready),
        .f_cdb(f_cdb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RSV_ID_W-1:0] rob;
        logic [INSTR_W-1:0]  op;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic                dready;
        logic [RSV_ID_W-1:0] dtag;
        logic                committed;
        logic                inval;
    } st_t;

    st_t q[$];
    int  head_m, starve_m, checks, failures, next_rob, writes;
    logic e_a_ready, e_m_valid, e_f_valid, e_push, e_swin, e_grant, e_drain, e_ipop;
    logic [42:0] e_m_bus;
    logic [CDB_W-1:0] e_f;
    logic [DATA_W-1:0] addr_pool [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int youngest(input logic [DATA_W-1:0] a);
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].addr == a) return i;
        return -1;
    endfunction

    function automatic int oldest_uncommitted();
        for (int i = 0; i < q.size(); i++) if (!q[i].committed) return i;
        return -1;
    endfunction

    task automatic model_expect();
        bit load, io, bypass, fwd;
        int y;
        e_a_ready = 0; e_m_valid = 0; e_f_valid = 0; e_push = 0; e_swin = 0;
        e_grant = 0; e_drain = 0; e_ipop = 0; e_m_bus = '0; e_f = '0;
        if (nrst) return;
        load   = a_valid && !a_is_store && !flush;
        y      = youngest(a_address);
        io     = (a_address == IO_ADDR);
        bypass = load && (io ? (q.size() == 0) : (y < 0));
        fwd    = load && !io && (y >= 0) && q[y].dready;
        e_drain = (q.size() > 0) && q[0].committed && q[0].dready && !q[0].inval;
        e_ipop  = (q.size() > 0) && q[0].committed && q[0].inval;
        e_swin  = e_drain && (!bypass || starve_m == STARVE_LIMIT);
        e_grant = bypass && !e_swin;
        if (e_swin) begin
            e_m_valid = 1; e_m_bus = {q[0].op, q[0].rob, q[0].addr, q[0].data};
        end else if (e_grant) begin
            e_m_valid = 1; e_m_bus = {a_opcode, a_rob_id, a_address, 16'h0};
        end
        if (fwd) begin
            e_f_valid = 1; e_f = {a_rob_id, q[y].data};
        end
        e_push    = a_valid && a_is_store && (q.size() < SB_DEPTH) && !flush;
        e_a_ready = e_push || (e_grant && m_ready) || (fwd && f_cdb_ready);
    endtask

    task automatic model_update();
        st_t e;
        if (nrst) begin
            q.delete(); head_m = 0; starve_m = 0; return;
        end
        if (!e_drain || (e_swin && m_ready)) starve_m = 0;
        else if (e_grant)                   starve_m++;
        for (int i = 0; i < q.size(); i++)
            if (cdb_valid && !q[i].dready && q[i].dtag == cdb[CDB_W-1 -: RSV_ID_W]) begin
                q[i].dready = 1; q[i].data = cdb[DATA_W-1:0];
            end
        if (commit_valid)
            for (int i = 0; i < q.size(); i++)
                if (!q[i].committed && q[i].rob == commit_id) begin
                    q[i].committed = 1; q[i].inval = commit_invalidate; break;
                end
        if ((e_swin && m_ready) || e_ipop) begin
            void'(q.pop_front()); head_m++;
        end
        if (e_push) begin
            e.rob = a_rob_id; e.op = a_opcode; e.addr = a_address; e.dtag = a_data_rob_id;
            e.committed = 0; e.inval = 0;
            if (a_data_ready) begin
                e.dready = 1; e.data = a_data;
            end else if (cdb_valid && cdb[CDB_W-1 -: RSV_ID_W] == a_data_rob_id) begin
                e.dready = 1; e.data = cdb[DATA_W-1:0];
            end else begin
                e.dready = 0; e.data = '0;
            end
            q.push_back(e);
        end
        if (flush)
            for (int i = q.size() - 1; i >= 0; i--) if (!q[i].committed) q.delete(i);
    endtask

    task automatic eval();
        @(negedge clk);
        model_expect();
        chk("a_ready", a_ready, e_a_ready);
        chk("m_valid", m_valid, e_m_valid);
        chk("m_bus", {m_opcode, m_rob_id, m_address, m_data}, e_m_bus);
        chk("f_cdb_valid", f_cdb_valid, e_f_valid);
        chk("f_cdb", f_cdb, e_f);
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        eval();
        advance();
    endtask

    task automatic push_store(input logic [4:0] rob, input logic [15:0] addr, input logic [15:0] data,
                              input logic dr, input logic [4:0] dtag);
        a_valid = 1; a_is_store = 1; a_opcode = OP_STORE; a_rob_id = rob; a_address = addr;
        a_data = data; a_data_ready = dr; a_data_rob_id = dtag;
        tick();
        a_valid = 0;
    endtask

    task automatic set_load(input logic [4:0] rob, input logic [15:0] addr);
        a_valid = 1; a_is_store = 0; a_opcode = OP_LOAD; a_rob_id = rob; a_address = addr;
        a_data = '0; a_data_ready = 0;
    endtask

    task automatic commit_oldest(input logic inval);
        int idx;
        idx = oldest_uncommitted();
        commit_valid = (idx >= 0); commit_id = (idx >= 0) ? q[idx].rob : '0;
        commit_invalidate = inval;
        tick();
        commit_valid = 0; commit_invalidate = 0;
    endtask

    task automatic drain_all();
        int idx;
        m_ready = 1;
        for (int n = 0; n < 64 && q.size() > 0; n++) begin
            idx = oldest_uncommitted();
            commit_valid = (idx >= 0); commit_id = (idx >= 0) ? q[idx].rob : '0;
            tick();
        end
        commit_valid = 0;
        chk("drain_count", dut.count, 0);
    endtask

    initial begin
        checks = 0; failures = 0; head_m = 0; starve_m = 0; next_rob = 0;
        addr_pool[0] = 16'h0100; addr_pool[1] = 16'h0104; addr_pool[2] = 16'h0108; addr_pool[3] = IO_ADDR;
        nrst = 1; a_valid = 0; a_is_store = 0; a_opcode = '0; a_rob_id = '0; a_address = '0;
        a_data = '0; a_data_rob_id = '0; a_data_ready = 0; cdb = '0; cdb_valid = 0;
        commit_valid = 0; commit_id = '0; commit_invalidate = 0; flush = 0;
        m_ready = 0; f_cdb_ready = 0;

        // reset: outputs quiet even with a store offered
        @(posedge clk); #1;
        a_valid = 1; a_is_store = 1;
        eval();
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        advance();
        tick();
        nrst = 0; a_valid = 0;
        tick();
        chk("rst_count", dut.count, 0);

        // fill 8, ninth refused, pop at full still refuses, then accepted with tail wrap
        for (int i = 0; i < 8; i++) push_store(5'(i), 16'h0200 + 16'(i), 16'h1000 + 16'(i), 1, '0);
        a_valid = 1; a_is_store = 1; a_rob_id = 5'd8; a_address = 16'h0208; a_data = 16'h1008; a_data_ready = 1;
        eval();
        chk("fill_9th_refused", a_ready, 1'b0);
        advance();
        commit_valid = 1; commit_id = 5'd0; tick(); commit_valid = 0;
        m_ready = 1;
        eval();
        chk("full_pop_refuse", a_ready, 1'b0);
        chk("full_pop_mvalid", m_valid, 1'b1);
        advance();
        eval();
        chk("9th_accepted", a_ready, 1'b1);
        advance();
        a_valid = 0;
        chk("tail_wrap", dut.tail, 1);
        drain_all();

        // forwarding from the single matching store
        m_ready = 1; f_cdb_ready = 1;
        push_store(5'd9, 16'h0100, 16'h0055, 1, '0);
        set_load(5'd20, 16'h0100);
        eval();
        chk("fwd_valid", f_cdb_valid, 1'b1);
        chk("fwd_data", f_cdb, {5'd20, 16'h0055});
        chk("fwd_no_mem", m_valid, 1'b0);
        advance();
        a_valid = 0;

        // youngest match wins
        push_store(5'd10, 16'h0100, 16'h0011, 1, '0);
        push_store(5'd11, 16'h0100, 16'h0022, 1, '0);
        set_load(5'd21, 16'h0100);
        eval();
        chk("youngest_data", f_cdb, {5'd21, 16'h0022});
        advance();
        a_valid = 0;

        // youngest match without data stalls until its CDB tag arrives
        push_store(5'd12, 16'h0100, 16'h0000, 0, 5'd25);
        set_load(5'd22, 16'h0100);
        eval(); chk("nr_stall0", a_ready, 1'b0); advance();
        eval(); chk("nr_stall1", f_cdb_valid, 1'b0); advance();
        cdb_valid = 1; cdb = {5'd25, 16'h0077};
        eval(); chk("nr_stall_cdb", a_ready, 1'b0); advance();
        cdb_valid = 0;
        eval(); chk("nr_fwd", f_cdb, {5'd22, 16'h0077}); advance();
        a_valid = 0;
        drain_all();

        // starvation: four bypass loads, then the committed store takes the port
        push_store(5'd13, 16'h0300, 16'h0033, 1, '0);
        m_ready = 0;
        commit_oldest(0);
        m_ready = 1;
        for (int k = 1; k <= 5; k++) begin
            set_load(5'(16 + k), 16'h0400);
            eval();
            if (k < 5) chk("starve_load_wins", m_address, 16'h0400);
            else begin
                chk("starve_store_wins", m_address, 16'h0300);
                chk("starve_load_held", a_ready, 1'b0);
            end
            advance();
        end
        a_valid = 0;
        chk("starve_cleared", dut.starve_cnt, 0);

        // flush keeps only committed stores
        m_ready = 0;
        for (int i = 0; i < 5; i++) push_store(5'((14 + i) % 16), 16'h0500 + 16'(i), 16'h5000 + 16'(i), 1, '0);
        for (int i = 0; i < 3; i++) commit_oldest(0);
        flush = 1; tick(); flush = 0;
        chk("flush_count", dut.count, 3);
        chk("flush_tail", dut.tail, 1);
        m_ready = 1; writes = 0;
        for (int n = 0; n < 20; n++) begin
            eval();
            if (m_valid && m_ready) writes++;
            advance();
        end
        chk("flush_writes", writes, 3);

        // invalidated head pops without a memory request
        push_store(5'd3, 16'h0700, 16'h0077, 1, '0);
        commit_oldest(1);
        eval(); chk("inval_no_mvalid", m_valid, 1'b0); advance();
        chk("inval_popped", dut.count, 0);

        // IO loads stall behind any store and are never forwarded
        m_ready = 0;
        push_store(5'd4, 16'h0600, 16'h0066, 1, '0);
        set_load(5'd30, IO_ADDR);
        eval(); chk("io_stall", a_ready, 1'b0); chk("io_no_mem", m_valid, 1'b0); advance();
        a_valid = 0;
        push_store(5'd5, IO_ADDR, 16'h0099, 1, '0);
        set_load(5'd31, IO_ADDR);
        eval(); chk("io_no_fwd", f_cdb_valid, 1'b0); advance();
        a_valid = 0;
        drain_all();
        set_load(5'd31, IO_ADDR);
        eval(); chk("io_empty_bypass", m_valid, 1'b1); chk("io_empty_ready", a_ready, 1'b1); advance();
        a_valid = 0;

        // random traffic with a mid-run reset
        next_rob = 0;
        for (int n = 0; n < 2000; n++) begin
            int idx;
            nrst       = (n == 1000);
            a_valid    = ($urandom_range(0, 3) != 0);
            a_is_store = $urandom_range(0, 1);
            a_address  = addr_pool[$urandom_range(0, 3)];
            a_opcode   = INSTR_W'($urandom);
            a_rob_id   = a_is_store ? 5'(next_rob) : 5'(16 + $urandom_range(0, 15));
            a_data     = DATA_W'($urandom);
            a_data_ready  = $urandom_range(0, 1);
            a_data_rob_id = 5'(16 + $urandom_range(0, 15));
            cdb_valid  = $urandom_range(0, 1);
            cdb        = {5'(16 + $urandom_range(0, 15)), DATA_W'($urandom)};
            idx = oldest_uncommitted();
            commit_valid = (idx >= 0) && ($urandom_range(0, 2) == 0);
            commit_id    = (idx >= 0) ? q[idx].rob : '0;
            commit_invalidate = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 63) == 0);
            m_ready     = ($urandom_range(0, 3) != 0);
            f_cdb_ready = ($urandom_range(0, 3) != 0);
            eval();
            if (e_push) next_rob = (next_rob + 1) % 16;
            advance();
            if (n % 250 == 0) chk("rand_count", dut.count, q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
